// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream and instruction-memory write bundle for instr_loader.
//   master: program source / memory side (drives start, byte_valid, byte_data)
//   slave : loader side (drives byte_ready, write port, status and cpu_hold)
// Signals:
//   start       load request pulse
//   byte_valid  stream byte present
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   wr_en       instruction memory write strobe
//   wr_addr     word address of the write
//   wr_data     instruction word
//   busy        load in progress
//   done        last load succeeded
//   err         last load failed
//   word_count  words written by the current/last load
//   cpu_hold    keeps the CPU in reset while high
interface instr_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;
    logic              cpu_hold;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count, cpu_hold
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count, cpu_hold
    );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: receives a framed byte stream (length L, 4*L big-endian data
// bytes, XOR checksum) and writes the assembled 32-bit words to consecutive
// instruction memory addresses from 0. The CPU is held in reset until a frame
// has been loaded and its checksum verified.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_loader_if.slave (stream handshake, memory write port, status)
module instr_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   len_q, len_nx;
    logic [1:0]        idx_q, idx_nx;
    logic [7:0]        acc_q, acc_nx;
    logic [31:0]       data_q, data_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W:0]   cnt_q, cnt_nx;
    logic              wr_en_q, wr_en_nx;
    logic              ready_q, ready_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;
    logic              err_q, err_nx;
    logic              hold_q, hold_nx;
    logic              fire;

    assign fire = bus.byte_valid && ready_q;

    // Every output is a register; byte_ready is precomputed from the next
    // state so it is already valid in the cycle the state is entered.
    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        idx_nx   = idx_q;
        acc_nx   = acc_q;
        data_nx  = data_q;
        addr_nx  = addr_q;
        cnt_nx   = cnt_q;
        wr_en_nx = 1'b0;
        busy_nx  = busy_q;
        done_nx  = done_q;
        err_nx   = err_q;
        hold_nx  = hold_q;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_nx = S_LEN;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    acc_nx   = '0;
                    busy_nx  = 1'b1;
                    hold_nx  = 1'b1;
                end
            end
            S_LEN: begin
                if (fire) begin
                    if (bus.byte_data == 8'd0 || int'(bus.byte_data) > DEPTH) begin
                        state_nx = S_ERR;
                        err_nx   = 1'b1;
                        busy_nx  = 1'b0;
                    end else begin
                        state_nx = S_DATA;
                        len_nx   = (ADDR_W+1)'(bus.byte_data);
                        acc_nx   = acc_q ^ bus.byte_data;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    data_nx = {data_q[23:0], bus.byte_data};
                    acc_nx  = acc_q ^ bus.byte_data;
                    idx_nx  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_nx = S_WRITE;
                        wr_en_nx = 1'b1;
                        addr_nx  = cnt_q[ADDR_W-1:0];
                    end
                end
            end
            S_WRITE: begin
                cnt_nx   = cnt_q + 1'b1;
                state_nx = (cnt_q + 1'b1 == len_q) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (fire) begin
                    busy_nx = 1'b0;
                    if (bus.byte_data == acc_q) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        hold_nx  = 1'b0;
                    end else begin
                        state_nx = S_ERR;
                        err_nx   = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        ready_nx = (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CHK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state   <= state_nx;
            len_q   <= len_nx;
            idx_q   <= idx_nx;
            acc_q   <= acc_nx;
            data_q  <= data_nx;
            addr_q  <= addr_nx;
            cnt_q   <= cnt_nx;
            wr_en_q <= wr_en_nx;
            ready_q <= ready_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
            hold_q  <= hold_nx;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = cnt_q;
    assign bus.cpu_hold   = hold_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader (DEPTH=64, ADDR_W=6).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_instr_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    instr_loader_if #(.ADDR_W(6)) bus ();

    instr_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captured memory writes and handshake violations during WRITE cycles.
    logic [5:0]  wa [$];
    logic [31:0] wd [$];
    int          rdy_in_wr;
    logic [31:0] fw [64];

    always @(negedge clk) begin
        if (bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            if (bus.byte_ready) rdy_in_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
        else @(negedge clk);
        if (stall && $urandom_range(0, 2) != 0) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_frame(input int l, input int nw, input logic [7:0] flip, input bit stall);
        logic [7:0] c;
        logic [7:0] b;
        c = l[7:0];
        send_byte(l[7:0], stall);
        for (int i = 0; i < nw; i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = fw[i][k*8 +: 8];
                c ^= b;
                send_byte(b, stall);
            end
        end
        send_byte(c ^ flip, stall);
        bus.byte_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        rdy_in_wr = 0;
    endtask

    task automatic check_nominal_writes(input string tag);
        check({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, {26'd0, wa[0]}, 0);
            check({tag, "_d0"}, wd[0], 32'h00500093);
            check({tag, "_a1"}, {26'd0, wa[1]}, 1);
            check({tag, "_d1"}, wd[1], 32'h00A00113);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbad;
        total = 0;
        bad   = 0;
        rdy_in_wr = 0;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_ready", bus.byte_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_addr", bus.wr_addr, 0);
        check("rst_data", bus.wr_data, 0);
        check("rst_count", bus.word_count, 0);
        check("rst_hold", bus.cpu_hold, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // bytes offered while idle are not accepted
        bus.byte_valid = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.byte_ready, 0);
        bus.byte_valid = 1'b0;

        // nominal frame with hand-computed checksum 0x73
        fw[0] = 32'h00500093;
        fw[1] = 32'h00A00113;
        clear_log();
        pulse_start();
        check("nom_busy", bus.busy, 1);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 2; i++)
            for (int k = 3; k >= 0; k--) send_byte(fw[i][k*8 +: 8], 1'b0);
        send_byte(8'h73, 1'b0);
        check("nom_done", bus.done, 1);
        check("nom_err", bus.err, 0);
        check("nom_hold", bus.cpu_hold, 0);
        check("nom_busy_end", bus.busy, 0);
        check("nom_count", bus.word_count, 2);
        check("nom_ready_done", bus.byte_ready, 0);
        check("nom_rdy_in_wr", rdy_in_wr, 0);
        check_nominal_writes("nom");
        check("nom_addr_hold", bus.wr_addr, 1);
        bus.byte_valid = 1'b0;

        // bad length 0
        clear_log();
        pulse_start();
        send_byte(8'd0, 1'b0);
        bus.byte_valid = 1'b0;
        check("len0_err", bus.err, 1);
        check("len0_hold", bus.cpu_hold, 1);
        check("len0_ready", bus.byte_ready, 0);
        check("len0_done", bus.done, 0);
        repeat (3) @(negedge clk);
        check("len0_nwr", wa.size(), 0);

        // bad length 65
        clear_log();
        pulse_start();
        check("len65_clr_err", bus.err, 0);
        send_byte(8'd65, 1'b0);
        bus.byte_valid = 1'b0;
        check("len65_err", bus.err, 1);
        check("len65_hold", bus.cpu_hold, 1);
        check("len65_ready", bus.byte_ready, 0);
        check("len65_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("len65_nwr", wa.size(), 0);

        // start from ERR, then a checksum error frame
        clear_log();
        pulse_start();
        send_frame(2, 2, 8'h01, 1'b0);
        check("cks_err", bus.err, 1);
        check("cks_done", bus.done, 0);
        check("cks_hold", bus.cpu_hold, 1);
        check_nominal_writes("cks");

        // start from ERR then nominal frame under random stalls
        clear_log();
        pulse_start();
        send_frame(2, 2, 8'h00, 1'b1);
        check("stall_done", bus.done, 1);
        check("stall_hold", bus.cpu_hold, 0);
        check("stall_count", bus.word_count, 2);
        check("stall_rdy_in_wr", rdy_in_wr, 0);
        check_nominal_writes("stall");

        // full memory: word k = k
        for (int i = 0; i < 64; i++) fw[i] = i;
        clear_log();
        pulse_start();
        send_frame(64, 64, 8'h00, 1'b0);
        check("full_done", bus.done, 1);
        check("full_count", bus.word_count, 64);
        check("full_nwr", wa.size(), 64);
        nbad = 0;
        for (int i = 0; i < 64 && i < wa.size(); i++)
            if (wa[i] !== 6'(i) || wd[i] !== 32'(i)) nbad++;
        check("full_contents", nbad, 0);

        // reset after 5 bytes
        fw[0] = 32'h00500093;
        fw[1] = 32'h00A00113;
        pulse_start();
        send_byte(8'h02, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(fw[0][k*8 +: 8], 1'b0);
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.byte_ready, 0);
        check("mid_rst_wr_en", bus.wr_en, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_count", bus.word_count, 0);
        check("mid_rst_data", bus.wr_data, 0);
        check("mid_rst_hold", bus.cpu_hold, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        check("mid_rst_nwr", wa.size(), 0);

        // start during DATA is ignored
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        bus.byte_valid = 1'b0;
        pulse_start();
        check("ign_busy", bus.busy, 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0);
        for (int k = 3; k >= 0; k--) send_byte(fw[1][k*8 +: 8], 1'b0);
        send_byte(8'h73, 1'b0);
        bus.byte_valid = 1'b0;
        check("ign_done", bus.done, 1);
        check("ign_count", bus.word_count, 2);
        check_nominal_writes("ign");

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
